// File: rtl/player_keys_decoder.sv
// -----------------------------------------------------------------------------
// player_keys_decoder
//
// Turns the PS/2 scan-code byte stream from the keyboard receiver into player
// control signals. It tracks make and break codes, including the E0 extended
// prefix. When both directions are held, the one pressed last wins. A fresh
// press of the fire key produces a one-cycle fire strobe.
//
// Optional feature (macro PLAYER_FIRE_AUTOREPEAT_EN):
//   While fire is held, fire repeats once every REPEAT_FRAMES frames, counted
//   on startOfFrame. When the macro is undefined, startOfFrame is unused.
//
// Ports:
//   clk           in   system clock (VGA domain)
//   resetN        in   asynchronous active-low reset
//   din[7:0]      in   scan-code byte, valid while din_new is high
//   din_new       in   one-cycle byte strobe
//   startOfFrame  in   one-cycle pulse at the start of each video frame
//   right         out  right movement request (level)
//   left          out  left movement request (level)
//   fire          out  one-cycle shot request
// -----------------------------------------------------------------------------
module player_keys_decoder #(
   parameter logic [7:0]  RIGHT_CODE    = 8'h74,  // extended (E0) code
   parameter logic [7:0]  LEFT_CODE     = 8'h6B,  // extended (E0) code
   parameter logic [7:0]  FIRE_CODE     = 8'h29,  // plain code
   parameter int unsigned REPEAT_FRAMES = 8       // legal range 2..255
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic [7:0] din,
   input  logic       din_new,
   input  logic       startOfFrame,
   output logic       right,
   output logic       left,
   output logic       fire
);

   localparam logic [7:0] CODE_E0 = 8'hE0;
   localparam logic [7:0] CODE_F0 = 8'hF0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GOT_E0   = 2'd1,
      GOT_F0   = 2'd2,
      GOT_E0F0 = 2'd3
   } state_t;

   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } dir_t;

   state_t state_q, state_d;
   logic   right_held_q, right_held_d;
   logic   left_held_q,  left_held_d;
   logic   fire_held_q,  fire_held_d;
   dir_t   last_dir_q,   last_dir_d;
   logic   fire_q,       fire_d;

   // Completed-code classification for the current byte
   logic plain_make, plain_break, ext_make, ext_break;
   logic fresh_fire, fire_release, rep_pulse;

   // ---------------------------------------------------------------- FSM
   // NOTE: every signal written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      plain_make  = 1'b0;
      plain_break = 1'b0;
      ext_make    = 1'b0;
      ext_break   = 1'b0;
      if (din_new) begin
         unique case (state_q)
            IDLE: begin
               if (din == CODE_E0)      state_d = GOT_E0;
               else if (din == CODE_F0) state_d = GOT_F0;
               else                     plain_make = 1'b1;
            end
            GOT_E0: begin
               if (din == CODE_F0)      state_d = GOT_E0F0;
               else if (din == CODE_E0) state_d = GOT_E0;  // repeated prefix
               else begin
                  ext_make = 1'b1;
                  state_d  = IDLE;
               end
            end
            GOT_F0: begin
               plain_break = 1'b1;
               state_d     = IDLE;
            end
            GOT_E0F0: begin
               ext_break = 1'b1;
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------- key actions
   // A make code for a key already held is typematic repeat. It is ignored,
   // so it neither moves last_dir nor produces another fire pulse.
   assign fresh_fire   = plain_make  && (din == FIRE_CODE) && !fire_held_q;
   assign fire_release = plain_break && (din == FIRE_CODE);

   always_comb begin
      right_held_d = right_held_q;
      left_held_d  = left_held_q;
      fire_held_d  = fire_held_q;
      last_dir_d   = last_dir_q;

      if (fresh_fire)   fire_held_d = 1'b1;
      if (fire_release) fire_held_d = 1'b0;

      if (ext_make && (din == RIGHT_CODE) && !right_held_q) begin
         right_held_d = 1'b1;
         last_dir_d   = DIR_RIGHT;
      end
      if (ext_make && (din == LEFT_CODE) && !left_held_q) begin
         left_held_d = 1'b1;
         last_dir_d  = DIR_LEFT;
      end
      if (ext_break && (din == RIGHT_CODE)) right_held_d = 1'b0;
      if (ext_break && (din == LEFT_CODE))  left_held_d  = 1'b0;
   end

   // ------------------------------------------------------ fire auto-repeat
`ifdef PLAYER_FIRE_AUTOREPEAT_EN
   localparam logic [7:0] REPEAT_LAST = 8'(REPEAT_FRAMES - 1);

   logic [7:0] rep_cnt_q, rep_cnt_d;

   // A fire byte event in the same cycle as startOfFrame takes priority over
   // the frame count: the counter restarts from zero.
   always_comb begin
      rep_cnt_d = rep_cnt_q;
      rep_pulse = 1'b0;
      if (fresh_fire || fire_release) begin
         rep_cnt_d = 8'd0;
      end else if (fire_held_q && startOfFrame) begin
         if (rep_cnt_q == REPEAT_LAST) begin
            rep_cnt_d = 8'd0;
            rep_pulse = 1'b1;
         end else begin
            rep_cnt_d = rep_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) rep_cnt_q <= 8'd0;
      else         rep_cnt_q <= rep_cnt_d;
   end
`else
   logic unused_sof;
   assign unused_sof = startOfFrame;
   assign rep_pulse  = 1'b0;
`endif

   assign fire_d = fresh_fire | rep_pulse;

   // ------------------------------------------------------------ registers
   // NOTE: sequential state uses non-blocking assignments so that every flop
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= IDLE;
         right_held_q <= 1'b0;
         left_held_q  <= 1'b0;
         fire_held_q  <= 1'b0;
         last_dir_q   <= DIR_RIGHT;
         fire_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         right_held_q <= right_held_d;
         left_held_q  <= left_held_d;
         fire_held_q  <= fire_held_d;
         last_dir_q   <= last_dir_d;
         fire_q       <= fire_d;
      end
   end

   // --------------------------------------------------------------- outputs
   // When both directions are held, last_dir decides, so right and left are
   // never high together.
   assign right = right_held_q && (!left_held_q  || (last_dir_q == DIR_RIGHT));
   assign left  = left_held_q  && (!right_held_q || (last_dir_q == DIR_LEFT));
   assign fire  = fire_q;

endmodule

// File: tb/tb_player_keys_decoder.sv
// -----------------------------------------------------------------------------
// tb_player_keys_decoder
//
// Self-checking bench for player_keys_decoder. A behavioural model does the
// work of a reference. It keeps the bytes of a code in progress in a queue
// and the held directions in press order. Both directed sequences and random
// byte streams are compared cycle by cycle against it.
// -----------------------------------------------------------------------------
module tb_player_keys_decoder;

   localparam int unsigned RF = 4;  // REPEAT_FRAMES used for the DUT

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_new = 1'b0;
   logic       startOfFrame = 1'b0;
   logic       right, left, fire;

   player_keys_decoder #(
      .RIGHT_CODE   (8'h74),
      .LEFT_CODE    (8'h6B),
      .FIRE_CODE    (8'h29),
      .REPEAT_FRAMES(RF)
   ) dut (
      .clk         (clk),
      .resetN      (resetN),
      .din         (din),
      .din_new     (din_new),
      .startOfFrame(startOfFrame),
      .right       (right),
      .left        (left),
      .fire        (fire)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ model
   logic [7:0] pending[$];   // prefix bytes of the code in progress
   int         held_dirs[$]; // held directions, oldest press first (0=R,1=L)
   bit         m_fire_held;
   int         frames_held;  // frames seen since the current fire press
   bit         exp_fire;

   function automatic bit pending_has(input logic [7:0] b);
      foreach (pending[i]) if (pending[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit dir_held(input int d);
      foreach (held_dirs[i]) if (held_dirs[i] == d) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void dir_release(input int d);
      for (int i = held_dirs.size() - 1; i >= 0; i--)
         if (held_dirs[i] == d) held_dirs.delete(i);
   endfunction

   function automatic void model_reset();
      pending.delete();
      held_dirs.delete();
      m_fire_held = 1'b0;
      frames_held = 0;
      exp_fire    = 1'b0;
   endfunction

   function automatic void model_step(input logic [7:0] b, input bit nw, input bit sof);
      bit done, is_break, is_ext, fire_evt;
      int d;
      exp_fire = 1'b0;
      fire_evt = 1'b0;
      done     = 1'b0;
      is_break = 1'b0;
      is_ext   = 1'b0;
      if (nw) begin
         if (pending_has(8'hF0)) begin
            done = 1'b1; is_break = 1'b1; is_ext = pending_has(8'hE0);
         end else if (b == 8'hE0 || b == 8'hF0) begin
            pending.push_back(b);
         end else begin
            done = 1'b1; is_ext = pending_has(8'hE0);
         end
      end
      if (done) begin
         pending.delete();
         if (!is_ext && b == 8'h29) begin
            if (is_break) begin
               m_fire_held = 1'b0; frames_held = 0; fire_evt = 1'b1;
            end else if (!m_fire_held) begin
               m_fire_held = 1'b1; frames_held = 0; fire_evt = 1'b1;
               exp_fire = 1'b1;
            end
         end
         if (is_ext && (b == 8'h74 || b == 8'h6B)) begin
            d = (b == 8'h74) ? 0 : 1;
            if (is_break)          dir_release(d);
            else if (!dir_held(d)) held_dirs.push_back(d);
         end
      end
`ifdef PLAYER_FIRE_AUTOREPEAT_EN
      if (!fire_evt && m_fire_held && sof) begin
         frames_held++;
         if (frames_held % RF == 0) exp_fire = 1'b1;
      end
`endif
   endfunction

   function automatic bit exp_right();
      return held_dirs.size() > 0 && held_dirs[held_dirs.size() - 1] == 0;
   endfunction

   function automatic bit exp_left();
      return held_dirs.size() > 0 && held_dirs[held_dirs.size() - 1] == 1;
   endfunction

   // ------------------------------------------------------------ drivers
   int fire_seen;

   task automatic step(input logic [7:0] b, input bit nw, input bit sof, input string tag);
      @(negedge clk);
      din = b; din_new = nw; startOfFrame = sof;
      @(posedge clk);
      model_step(b, nw, sof);
      #1;
      check({tag, ".right"}, 32'(right), 32'(exp_right()));
      check({tag, ".left"},  32'(left),  32'(exp_left()));
      check({tag, ".fire"},  32'(fire),  32'(exp_fire));
      if (fire) fire_seen++;
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0, tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      resetN = 1'b0; din_new = 1'b0; startOfFrame = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check({tag, ".right"}, 32'(right), 32'd0);
      check({tag, ".left"},  32'(left),  32'd0);
      check({tag, ".fire"},  32'(fire),  32'd0);
      resetN = 1'b1;
   endtask

   function automatic logic [7:0] pick_byte();
      logic [7:0] pool[8];
      pool = '{8'hE0, 8'hF0, 8'h74, 8'h6B, 8'h29, 8'hAA, 8'hFA, 8'h1C};
      return pool[$urandom_range(7)];
   endfunction

   // ------------------------------------------------------------ sequence
   initial begin
      model_reset();
      do_reset("reset");

      // Right press and release
      step(8'hE0, 1, 0, "r_press"); step(8'h74, 1, 0, "r_press");
      check("r_press.right_level", 32'(right), 32'd1);
      idle(2, "r_hold");
      step(8'hE0, 1, 0, "r_rel"); step(8'hF0, 1, 0, "r_rel"); step(8'h74, 1, 0, "r_rel");
      check("r_rel.right_level", 32'(right), 32'd0);

      // Last pressed wins, release restores the other direction
      step(8'hE0, 1, 0, "hold_r"); step(8'h74, 1, 0, "hold_r");
      step(8'hE0, 1, 0, "press_l"); step(8'h6B, 1, 0, "press_l");
      check("press_l.left_level", 32'({left, right}), 32'b10);
      step(8'hE0, 1, 0, "typematic_r"); step(8'h74, 1, 0, "typematic_r");
      check("typematic_r.left_wins", 32'({left, right}), 32'b10);
      step(8'hE0, 1, 0, "rel_l"); step(8'hF0, 1, 0, "rel_l"); step(8'h6B, 1, 0, "rel_l");
      check("rel_l.right_back", 32'({left, right}), 32'b01);
      step(8'hE0, 1, 0, "rel_r"); step(8'hF0, 1, 0, "rel_r"); step(8'h74, 1, 0, "rel_r");
      idle(1, "gap");

      // Fire: pulse on fresh press only
      fire_seen = 0;
      step(8'h29, 1, 0, "fire1");
      idle(1, "fire1_end");
      step(8'h29, 1, 0, "fire_rep"); step(8'h29, 1, 0, "fire_rep");
      check("fire_once_count", 32'(fire_seen), 32'd1);
      step(8'hF0, 1, 0, "fire_brk"); step(8'h29, 1, 0, "fire_brk");
      step(8'h29, 1, 0, "fire2");
      check("fire2.pulse", 32'(fire), 32'd1);
      idle(1, "fire2_end");
      step(8'hF0, 1, 0, "fire2_brk"); step(8'h29, 1, 0, "fire2_brk");

      // Wrong-prefix codes are ignored
      step(8'h74, 1, 0, "bare74");
      step(8'hE0, 1, 0, "e0_29"); step(8'h29, 1, 0, "e0_29");
      check("wrong_prefix.outs", 32'({right, left, fire}), 32'd0);
      step(8'hAA, 1, 0, "aa"); step(8'hFA, 1, 0, "fa");

      // Reset in the middle of an extended sequence
      step(8'hE0, 1, 0, "pre_reset");
      do_reset("mid_reset");
      step(8'h74, 1, 0, "post_reset");
      check("post_reset.right", 32'(right), 32'd0);
      step(8'hE0, 1, 0, "idle_proof"); step(8'h74, 1, 0, "idle_proof");
      check("idle_proof.right", 32'(right), 32'd1);
      step(8'hE0, 1, 0, "idle_proof_rel"); step(8'hF0, 1, 0, "idle_proof_rel");
      step(8'h74, 1, 0, "idle_proof_rel");

`ifdef PLAYER_FIRE_AUTOREPEAT_EN
      // Auto-repeat: one pulse at press, then every RF frames
      fire_seen = 0;
      step(8'h29, 1, 0, "ar_press");
      for (int i = 0; i < 8; i++) begin
         step(8'h00, 0, 1, "ar_frame");
         idle(2, "ar_gap");
      end
      check("ar.pulse_count", 32'(fire_seen), 32'd3);
      step(8'hF0, 1, 0, "ar_brk"); step(8'h29, 1, 0, "ar_brk");
      fire_seen = 0;
      for (int i = 0; i < 8; i++) step(8'h00, 0, 1, "ar_after");
      check("ar.after_break", 32'(fire_seen), 32'd0);
      // Byte event and frame pulse together: make wins, then break wins
      step(8'h29, 1, 1, "ar_coinc_make");
      step(8'hF0, 1, 0, "ar_coinc_brk"); step(8'h29, 1, 1, "ar_coinc_brk");
`endif

      // Random streams, including back-to-back strobes
      for (int i = 0; i < 3000; i++) begin
         step(pick_byte(), ($urandom_range(9) < 7), ($urandom_range(9) < 2), "rand");
         if (i % 1000 == 999) do_reset("rand_reset");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/player_keys_decoder.md
# player_keys_decoder

Converts the PS/2 scan-code byte stream from the keyboard receiver into the player control signals consumed by the player-movement block: held levels `right` and `left`, plus a single-cycle `fire` strobe. It sits between the keyboard byte receiver and the player/shot logic, and runs in the VGA clock domain. It tracks make and break codes, including the E0 extended prefix. Direction conflicts resolve last-pressed-wins, and the fire strobe optionally auto-repeats at frame rate.

## Interface
Parameters:
- `RIGHT_CODE`, default 8'h74: right arrow scan code; recognized only after an E0 prefix.
- `LEFT_CODE`, default 8'h6B: left arrow scan code; recognized only after an E0 prefix.
- `FIRE_CODE`, default 8'h29: space bar scan code; recognized only without an E0 prefix.
- `REPEAT_FRAMES`, default 8: fire auto-repeat period in frames. Legal range is 2..255.

Ports:
- `clk`  in  1: system clock.
- `resetN`  in  1: reset, asynchronous and active-low.
- `din`  in  8: scan-code byte from the keyboard receiver.
- `din_new`  in  1: one-cycle strobe; `din` is valid while it is high.
- `startOfFrame`  in  1: one-cycle pulse at the start of each video frame.
- `right`  out  1: right movement request (level).
- `left`  out  1: left movement request (level).
- `fire`  out  1: one-cycle shot request.

## Operation
- Bytes are consumed only on cycles where `din_new`=1. All other cycles leave the decoder state unchanged.
- The decoder FSM has four states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions:
  - IDLE: E0 → GOT_E0; F0 → GOT_F0; any other byte is a plain make code, then the FSM stays in IDLE.
  - GOT_E0: F0 → GOT_E0F0; E0 → stay in GOT_E0; any other byte is an extended make code, then → IDLE.
  - GOT_F0: any byte is a plain break code, then → IDLE.
  - GOT_E0F0: any byte is an extended break code, then → IDLE.
- Code-to-action mapping:
  - Plain make of FIRE_CODE sets `fireHeld`.
  - Plain break of FIRE_CODE clears `fireHeld`.
  - Extended make of RIGHT_CODE / LEFT_CODE sets `rightHeld` / `leftHeld` and writes `lastDir` to that direction.
  - Extended break of RIGHT_CODE / LEFT_CODE clears the matching held bit.
  - All other codes, including AA, FA and unmapped keys, are ignored.
- A make code for a key that is already held is a typematic repeat and is ignored entirely: `lastDir` is unchanged and no fire pulse is generated.
- Output equations:
  - `right` = `rightHeld` & (!`leftHeld` | `lastDir`==RIGHT).
  - `left` = `leftHeld` & (!`rightHeld` | `lastDir`==LEFT).
  - `right` and `left` are never high together.
- `fire` pulses for one cycle on a fresh make of FIRE_CODE, i.e. a make while `fireHeld`=0.
- Reset clears the FSM to IDLE and clears `rightHeld`, `leftHeld`, `fireHeld`, `lastDir` (RIGHT) and the repeat counter. All outputs reset to 0.

## Timing
- Held bits and `fire` are registered on the clock edge that samples the completing `din_new`. `right`/`left` change in the cycle after that edge; `fire` is high for exactly that one cycle.
- Latency from the final byte strobe to the output is 1 clock.
- A reset assertion mid-sequence, e.g. after E0, discards the partial sequence. The next byte is decoded from IDLE.
- Back-to-back `din_new` strobes on consecutive cycles are supported; one byte is processed per cycle.

## Configuration
- Macro: `PLAYER_FIRE_AUTOREPEAT_EN`.
- When defined, a counter (8-bit, cleared on reset) runs while `fireHeld`=1:
  - The counter is cleared to 0 on a fresh fire make and on fire break.
  - On each `startOfFrame` while held, the counter increments. When the increment would reach REPEAT_FRAMES, `fire` pulses one cycle and the counter returns to 0.
  - Result: one pulse at press, then one pulse every REPEAT_FRAMES frames.
  - If a byte event and `startOfFrame` occur in the same cycle, the byte event takes priority:
    - A fresh make in that cycle gives one pulse and counter=0.
    - A break in that cycle gives no pulse and counter=0.
- When the macro is undefined, the counter logic is absent, `startOfFrame` is unused, and `fire` pulses only once per press.

## Test plan
- Send E0,74 → `right`=1, `left`=0 one cycle after the 74 strobe. Then send E0,F0,74 → `right`=0.
- Hold right (E0,74), then press left (E0,6B) → `left`=1, `right`=0. Release left (E0,F0,6B) → `right`=1 again.
- Send 29 → `fire` high exactly 1 cycle. Send 29,29 again without a break → no further pulse. Send F0,29 then 29 → a new pulse.
- Send a bare 74 (no E0), then E0,29 → `right`, `left` and `fire` all stay 0.
- Send E0, assert `resetN`=0 for 2 cycles, release, send 74 → `right` stays 0 and the FSM is in IDLE.
- With `PLAYER_FIRE_AUTOREPEAT_EN` and REPEAT_FRAMES=4: send 29, then pulse `startOfFrame` 8 times → 3 `fire` pulses total (at the press and on the 4th and 8th frames). Send F0,29 → no further pulses.
